// File: rtl/cpu_defs.sv
// Shared constants for the fetch stage: address map, AdEL exception code and
// fetch FSM state encoding.
package cpu_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_4FFF;

    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_addr_chk.sv
// Combinational fetch-address legality check (range + word alignment).
// A killed fetch never reports a fault since its instruction is discarded.
module fetch_addr_chk
    import cpu_defs::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_kill,
    output logic        o_exc,
    output logic [4:0]  o_exccode
);

    logic w_bad;

    assign w_bad     = (i_pc < IM_LO) || (i_pc > IM_HI) || (i_pc[1:0] != 2'b00);
    assign o_exc     = w_bad && !i_kill;
    assign o_exccode = o_exc ? EXC_ADEL : 5'd0;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: sequential / branch / exception / eret next-PC and
// eret drain bubbles. Optional perf counters under `FETCH_PERF_EN.
module fetch_ctrl
    import cpu_defs::*;
#(
    parameter int ERET_DRAIN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_D,
    input  logic [31:0] epc,
    output logic [31:0] pc_F,
    output logic        fetch_kill,
    output logic        fetch_exc,
    output logic [4:0]  fetch_exccode,
    output logic        draining
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
`endif
);

    localparam logic [1:0] DRAIN_LOAD = 2'(ERET_DRAIN - 1);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [1:0]   r_cnt, w_cnt_nxt;
    logic         w_pc_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Exception entry beats everything, including stall and an in-flight drain.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_pc_load   = 1'b0;
        if (exc_req) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = HANDLER_PC;
            w_cnt_nxt   = 2'd0;
            w_pc_load   = 1'b1;
        end else if (r_state == ST_DRAIN) begin
            if (!stall) begin
                if (r_cnt != 2'd0) begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = epc;
                    w_pc_load   = 1'b1;
                end
            end
        end else if (eret_D && !stall) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = DRAIN_LOAD;
        end else if (!stall) begin
            w_pc_nxt  = br_taken ? br_target : r_pc + 32'd4;
            w_pc_load = 1'b1;
        end
    end

    assign pc_F       = r_pc;
    assign draining   = (r_state == ST_DRAIN);
    assign fetch_kill = (r_state == ST_DRAIN) || (r_state == ST_RUN && eret_D);

    fetch_addr_chk u_addr_chk (
        .i_pc      (r_pc),
        .i_kill    (fetch_kill),
        .o_exc     (fetch_exc),
        .o_exccode (fetch_exccode)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch, r_perf_bubble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetch  <= 32'd0;
            r_perf_bubble <= 32'd0;
        end else begin
            if (w_pc_load)           r_perf_fetch  <= r_perf_fetch + 32'd1;
            if (fetch_kill || stall) r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_fetch  = r_perf_fetch;
    assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected fetch state is queued when stimulus
// is driven and popped/compared once the DUT has reacted.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, exc_req, eret_D;
    logic [31:0] br_target, epc, pc_F;
    logic        fetch_kill, fetch_exc, draining;
    logic [4:0]  fetch_exccode;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_bubble;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        kill;
        logic        exc;
        logic        drain;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .exc_req       (exc_req),
        .eret_D        (eret_D),
        .epc           (epc),
        .pc_F          (pc_F),
        .fetch_kill    (fetch_kill),
        .fetch_exc     (fetch_exc),
        .fetch_exccode (fetch_exccode),
        .draining      (draining)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch    (perf_fetch),
        .perf_bubble   (perf_bubble)
`endif
    );

    task automatic push(input string tag, input logic [31:0] pc, input logic kill,
                        input logic exc, input logic drain);
        exp_t e;
        e.tag = tag; e.pc = pc; e.kill = kill; e.exc = exc; e.drain = drain;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t       e;
        logic [4:0] code;
        e    = sb.pop_front();
        code = e.exc ? 5'd4 : 5'd0;
        checks++;
        assert (pc_F === e.pc) else begin
            failures++; $error("FAIL %s pc_F got=%h exp=%h", e.tag, pc_F, e.pc);
        end
        checks++;
        assert (fetch_kill === e.kill) else begin
            failures++; $error("FAIL %s fetch_kill got=%b exp=%b", e.tag, fetch_kill, e.kill);
        end
        checks++;
        assert (fetch_exc === e.exc) else begin
            failures++; $error("FAIL %s fetch_exc got=%b exp=%b", e.tag, fetch_exc, e.exc);
        end
        checks++;
        assert (fetch_exccode === code) else begin
            failures++; $error("FAIL %s fetch_exccode got=%0d exp=%0d", e.tag, fetch_exccode, code);
        end
        checks++;
        assert (draining === e.drain) else begin
            failures++; $error("FAIL %s draining got=%b exp=%b", e.tag, draining, e.drain);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expectation after the next rising edge.
    task automatic at_edge(input string tag, input logic [31:0] pc, input logic kill,
                           input logic exc, input logic drain);
        push(tag, pc, kill, exc, drain);
        tick();
        chk();
    endtask

    // Expectation for the combinational response, no edge in between.
    task automatic now(input string tag, input logic [31:0] pc, input logic kill,
                       input logic exc, input logic drain);
        push(tag, pc, kill, exc, drain);
        #1;
        chk();
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0; exc_req = 1'b0; eret_D = 1'b0;
        br_target = 32'd0; epc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        now("reset", 32'h3000, 0, 0, 0);
        reset = 1'b1;
        at_edge("seq1", 32'h3004, 0, 0, 0);
        at_edge("seq2", 32'h3008, 0, 0, 0);
        at_edge("seq3", 32'h300C, 0, 0, 0);

        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
        now("stall_hold0", 32'h300C, 0, 0, 0);
        at_edge("stall_hold1", 32'h300C, 0, 0, 0);
        at_edge("stall_hold2", 32'h300C, 0, 0, 0);
        stall = 1'b0;
        at_edge("br_release", 32'h3100, 0, 0, 0);
        br_target = 32'h3020;
        at_edge("br_3020", 32'h3020, 0, 0, 0);

        // eret with a competing branch that must be ignored
        eret_D = 1'b1; epc = 32'h3404; br_target = 32'h3500;
        now("eret_t0", 32'h3020, 1, 0, 0);
        at_edge("eret_t1", 32'h3020, 1, 0, 1);
        eret_D = 1'b0; br_taken = 1'b0; epc = 32'h1111_0000;
        at_edge("eret_t2", 32'h3020, 1, 0, 1);
        at_edge("eret_t3", 32'h3020, 1, 0, 1);
        epc = 32'h3404;
        at_edge("eret_redirect", 32'h3404, 0, 0, 0);
        at_edge("seq_after_eret", 32'h3408, 0, 0, 0);

        eret_D = 1'b1; epc = 32'h3600;
        now("sd_t0", 32'h3408, 1, 0, 0);
        at_edge("sd_t1", 32'h3408, 1, 0, 1);
        eret_D = 1'b0; stall = 1'b1;
        at_edge("sd_stall1", 32'h3408, 1, 0, 1);
        at_edge("sd_stall2", 32'h3408, 1, 0, 1);
        stall = 1'b0;
        at_edge("sd_t2", 32'h3408, 1, 0, 1);
        at_edge("sd_t3", 32'h3408, 1, 0, 1);
        at_edge("sd_redirect", 32'h3600, 0, 0, 0);

        eret_D = 1'b1; epc = 32'h3700;
        at_edge("xd_drain", 32'h3600, 1, 0, 1);
        eret_D = 1'b0; exc_req = 1'b1; stall = 1'b1;
        now("xd_pre", 32'h3600, 1, 0, 1);
        at_edge("xd_handler", 32'h4180, 0, 0, 0);
        exc_req = 1'b0; stall = 1'b0;
        at_edge("xd_seq", 32'h4184, 0, 0, 0);

        eret_D = 1'b1;
        at_edge("rd_drain", 32'h4184, 1, 0, 1);
        eret_D = 1'b0;
        #2 reset = 1'b0;
        now("rd_async", 32'h3000, 0, 0, 0);
        reset = 1'b1;
        at_edge("rd_seq", 32'h3004, 0, 0, 0);

        br_taken = 1'b1; br_target = 32'h3002;
        at_edge("adel_misalign", 32'h3002, 0, 1, 0);
        br_taken = 1'b0; eret_D = 1'b1;
        now("adel_killed", 32'h3002, 1, 0, 0);
        eret_D = 1'b0; br_taken = 1'b1; br_target = 32'h4FFC;
        at_edge("im_top", 32'h4FFC, 0, 0, 0);
        br_taken = 1'b0;
        at_edge("im_over", 32'h5000, 0, 1, 0);
        exc_req = 1'b1;
        at_edge("adel_handler", 32'h4180, 0, 0, 0);
        exc_req = 1'b0;

        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        at_edge("wrap_pre", 32'hFFFF_FFFC, 0, 1, 0);
        br_taken = 1'b0;
        at_edge("wrap", 32'h0000_0000, 0, 1, 0);
        br_taken = 1'b1; br_target = 32'h2FFC;
        at_edge("below_lo", 32'h2FFC, 0, 1, 0);
        br_target = 32'h3000;
        at_edge("lo_edge", 32'h3000, 0, 0, 0);
        br_taken = 1'b0;

`ifdef FETCH_PERF_EN
        checks++;
        assert (perf_fetch !== 32'd0 && perf_bubble !== 32'd0) else begin
            failures++; $error("FAIL perf counters got=%0d/%0d exp=nonzero", perf_fetch, perf_bubble);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
